// File: rtl/clksel_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | clksel_ctrl : per-bus-cycle high/low speed clock policy with shadowed   |
// |               divider configuration and hysteresis.   Rev 1.0          |
// +------------------------------------------------------------------------+
module clksel_ctrl #(
  parameter logic [23:0] CFG_ADDR    = 24'h00FE4E,
  parameter logic [15:0] IO_LO       = 16'hFC00,
  parameter logic [15:0] HS_TOP      = 16'h8000,
  parameter int          HOLD_CYCLES = 4,
  parameter int          SETTLE      = 16
) (
  input  logic        hsclk_in,
  input  logic        rst,
  input  logic        cyc_valid,
  input  logic [23:0] addr,
  input  logic        rnw,
  input  logic [7:0]  wdata,
  output logic        hsclk_sel,
  output logic [1:0]  hsclk_div_sel,
  output logic [1:0]  cpuclk_div_sel,
  output logic [7:0]  cfg_rdata
);

  localparam logic [3:0] c_HOLD   = HOLD_CYCLES[3:0];
  localparam logic [7:0] c_SETTLE = SETTLE[7:0];

  typedef enum logic [1:0] {
    ST_LS      = 2'd0,
    ST_HS      = 2'd1,
    ST_LS_HOLD = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_hsclk_sel;
  logic [3:0] r_hold;
  logic [7:0] r_settle;
  logic       r_hs_en;
  logic [1:0] r_hs_sh;
  logic [1:0] r_cpu_sh;
  logic [1:0] r_hs_div;
  logic [1:0] r_cpu_div;

  logic w_bank0;
  logic w_ls_region;
  logic w_hs_region;
  logic w_cfg_wr;
  logic w_settled;
  logic w_ready;
  logic w_unused;

  // The I/O window is always slow, even if it were configured below HS_TOP.
  assign w_bank0     = (addr[23:16] == 8'h00);
  assign w_ls_region = w_bank0 & ((addr[15:0] >= HS_TOP) | (addr[15:0] >= IO_LO));
  assign w_hs_region = ~w_ls_region;
  assign w_cfg_wr    = cyc_valid & ~rnw & (addr == CFG_ADDR);
  assign w_settled   = (r_settle == c_SETTLE);
  assign w_ready     = r_hs_en & w_settled & (r_hs_div == r_hs_sh) & (r_cpu_div == r_cpu_sh);
  assign w_unused    = ^wdata[7:5];

  always_ff @(posedge hsclk_in) begin
    if (rst) begin
      r_state     <= ST_LS;
      r_hsclk_sel <= 1'b0;
      r_hold      <= 4'd0;
    end else if (cyc_valid) begin
      case (r_state)
        ST_LS: begin
          if (w_hs_region & w_ready) begin
            r_state     <= ST_HS;
            r_hsclk_sel <= 1'b1;
          end
        end
        ST_HS: begin
          if (w_ls_region | ~r_hs_en) begin
            r_state     <= ST_LS_HOLD;
            r_hsclk_sel <= 1'b0;
            r_hold      <= c_HOLD;
          end
        end
        ST_LS_HOLD: begin
          // Any slow access restarts the hysteresis window.
          if (w_ls_region) begin
            r_hold <= c_HOLD;
          end else if (r_hold > 4'd1) begin
            r_hold <= r_hold - 4'd1;
          end else begin
            r_state <= ST_LS;
            r_hold  <= 4'd0;
          end
        end
        default: begin
          r_state     <= ST_LS;
          r_hsclk_sel <= 1'b0;
          r_hold      <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge hsclk_in) begin
    if (rst) begin
      r_hs_en   <= 1'b0;
      r_hs_sh   <= 2'd0;
      r_cpu_sh  <= 2'd0;
      r_settle  <= 8'd0;
      r_hs_div  <= 2'd0;
      r_cpu_div <= 2'd0;
    end else begin
      if (w_cfg_wr) begin
        r_hs_en  <= wdata[0];
        r_hs_sh  <= wdata[2:1];
        r_cpu_sh <= wdata[4:3];
      end
      if (r_hsclk_sel) begin
        r_settle <= 8'd0;
      end else if (!w_settled) begin
        r_settle <= r_settle + 8'd1;
      end
      // Dividers may only move while parked and settled on the slow clock.
      if (~r_hsclk_sel & w_settled) begin
        r_hs_div  <= r_hs_sh;
        r_cpu_div <= r_cpu_sh;
      end
    end
  end

  assign hsclk_sel      = r_hsclk_sel;
  assign hsclk_div_sel  = r_hs_div;
  assign cpuclk_div_sel = r_cpu_div;
  assign cfg_rdata      = {r_hsclk_sel, 2'b00, r_cpu_sh, r_hs_sh, r_hs_en};

endmodule
`default_nettype wire
